// File: rtl/macout_pkg.sv
// Shared encodings for the MAC output stage: post-process modes and framing states.
package macout_pkg;

    localparam logic [1:0] MODE_SEXT     = 2'b00;
    localparam logic [1:0] MODE_RND      = 2'b01;
    localparam logic [1:0] MODE_RELU     = 2'b10;
    localparam logic [1:0] MODE_RND_RELU = 2'b11;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_INFRAME = 1'b1
    } frame_state_e;

endpackage

// File: rtl/macout_fifo.sv
// Synchronous FIFO with occupancy count; head word is presented combinationally.
module macout_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q != (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/macout_stage.sv
// MAC output stage: per-column round/ReLU/saturate, one register stage, then an
// output FIFO; tracks frame delimiters and latches mode/shift per frame.
module macout_stage
    import macout_pkg::*;
#(
    parameter int COLUMN = 6,
    parameter int CW     = 19,
    parameter int OW     = 22,
    parameter int DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COLUMN*CW-1:0] mac_m_data,
    input  logic                 mac_m_first,
    input  logic                 mac_m_last,
    input  logic                 mac_m_valid,
    output logic                 mac_m_ready,
    input  logic [1:0]           mode,
    input  logic [4:0]           shift,
    input  logic                 sat_clr,
    output logic [COLUMN*OW-1:0] macd_s_data,
    output logic                 macd_s_first,
    output logic                 macd_s_last,
    output logic                 macd_s_valid,
    input  logic                 macd_s_ready,
    output logic                 sat_flag,
    output logic                 frame_err
);
    localparam int DW   = COLUMN * OW;
    localparam int FW   = DW + 2;
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic                accept;
    logic                pop;
    logic [CNTW-1:0]     fifo_count;
    logic                fifo_empty;
    logic [FW-1:0]       fifo_head;

    logic                s1_valid_q;
    logic                s1_first_q;
    logic                s1_last_q;
    logic [DW-1:0]       s1_data_q;

    frame_state_e        state_q;
    logic [1:0]          mode_q;
    logic [4:0]          shift_q;
    logic                sat_flag_q;
    logic                frame_err_q;

    logic [1:0]          mode_eff;
    logic [4:0]          shift_raw;
    logic [4:0]          shift_eff;
    logic [4:0]          sh_amt;
    logic                do_rnd;
    logic                do_relu;
    logic signed [CW:0]  rnd_add;
    logic [DW-1:0]       proc_data;
    logic [COLUMN-1:0]   col_sat;
    logic                frame_viol;

    // Counting the S1 beat guarantees the FIFO always has room when S1 drains.
    assign mac_m_ready = ({1'b0, fifo_count} + {{CNTW{1'b0}}, s1_valid_q})
                         < (CNTW+1)'(DEPTH);
    assign accept      = mac_m_valid && mac_m_ready;
    assign pop         = macd_s_valid && macd_s_ready;

    // A first beat and any beat outside a frame take the live settings.
    always_comb begin
        if (mac_m_first || (state_q == ST_IDLE)) begin
            mode_eff  = mode;
            shift_raw = shift;
        end else begin
            mode_eff  = mode_q;
            shift_raw = shift_q;
        end
        shift_eff = (int'(shift_raw) >= CW) ? 5'(CW - 1) : shift_raw;
        do_rnd    = (mode_eff == MODE_RND) || (mode_eff == MODE_RND_RELU);
        do_relu   = (mode_eff == MODE_RELU) || (mode_eff == MODE_RND_RELU);
        sh_amt    = do_rnd ? shift_eff : 5'd0;
        rnd_add   = (sh_amt == 5'd0) ? '0 : ((CW+1)'(1) << (sh_amt - 5'd1));
    end

    generate
        for (genvar gi = 0; gi < COLUMN; gi++) begin : g_col
            logic signed [CW-1:0] x;
            logic signed [CW:0]   xe;
            logic signed [CW:0]   y;

            assign x = mac_m_data[gi*CW +: CW];

            // CW+1 bits cannot overflow: the rounding bias is at most 2^(CW-2).
            always_comb begin
                xe = {x[CW-1], x};
                y  = (xe + rnd_add) >>> sh_amt;
                if (do_relu && y[CW]) begin
                    y = '0;
                end
            end

            if (OW >= CW) begin : g_ext
                assign proc_data[gi*OW +: OW] = OW'(y);
                assign col_sat[gi]            = 1'b0;
            end else begin : g_sat
                localparam logic signed [CW:0] SAT_MAX = {{(CW-OW+2){1'b0}}, {(OW-1){1'b1}}};
                localparam logic signed [CW:0] SAT_MIN = {{(CW-OW+2){1'b1}}, {(OW-1){1'b0}}};

                assign col_sat[gi] = (y > SAT_MAX) || (y < SAT_MIN);
                assign proc_data[gi*OW +: OW] = (y > SAT_MAX) ? SAT_MAX[OW-1:0] :
                                                (y < SAT_MIN) ? SAT_MIN[OW-1:0] :
                                                y[OW-1:0];
            end
        end
    endgenerate

    assign frame_viol = (mac_m_first && (state_q == ST_INFRAME)) ||
                        (mac_m_last && !mac_m_first && (state_q == ST_IDLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_first_q <= mac_m_first;
                s1_last_q  <= mac_m_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_data_q <= proc_data;
        end
    end

    // Framing FSM together with the per-frame settings and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_SEXT;
            shift_q     <= '0;
            sat_flag_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= accept && frame_viol;
            if (accept && (|col_sat)) begin
                sat_flag_q <= 1'b1;
            end else if (sat_clr) begin
                sat_flag_q <= 1'b0;
            end
            if (accept) begin
                if (mac_m_first) begin
                    mode_q  <= mode;
                    shift_q <= shift;
                end
                if (mac_m_last) begin
                    state_q <= ST_IDLE;
                end else if (mac_m_first) begin
                    state_q <= ST_INFRAME;
                end
            end
        end
    end

    macout_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (s1_valid_q),
        .data_i  ({s1_first_q, s1_last_q, s1_data_q}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    // Sidebands are gated by occupancy so reset clears them without a clock.
    assign macd_s_valid = !fifo_empty;
    assign macd_s_first = fifo_head[FW-1] && !fifo_empty;
    assign macd_s_last  = fifo_head[FW-2] && !fifo_empty;
    assign macd_s_data  = fifo_head[DW-1:0];
    assign sat_flag     = sat_flag_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_macout_stage.sv
// Scoreboard bench for macout_stage: a wide-output (OW=22) and a saturating
// (OW=8) instance share one stimulus stream and are checked against a model.
module tb_macout_stage;

    localparam int COLUMN = 6;
    localparam int CW     = 19;
    localparam int OWA    = 22;
    localparam int OWB    = 8;
    localparam int DEPTH  = 8;

    logic                   clk;
    logic                   rst;
    logic [COLUMN*CW-1:0]   mac_m_data;
    logic                   mac_m_first;
    logic                   mac_m_last;
    logic                   mac_m_valid;
    logic [1:0]             mode;
    logic [4:0]             shift;
    logic                   sat_clr;
    logic                   macd_s_ready;

    logic                   ready_a, ready_b;
    logic [COLUMN*OWA-1:0]  data_a;
    logic [COLUMN*OWB-1:0]  data_b;
    logic                   first_a, first_b, last_a, last_b;
    logic                   valid_a, valid_b;
    logic                   sat_a, sat_b;
    logic                   ferr_a, ferr_b;

    macout_stage #(.COLUMN(COLUMN), .CW(CW), .OW(OWA), .DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst(rst), .mac_m_data(mac_m_data), .mac_m_first(mac_m_first),
        .mac_m_last(mac_m_last), .mac_m_valid(mac_m_valid), .mac_m_ready(ready_a),
        .mode(mode), .shift(shift), .sat_clr(sat_clr), .macd_s_data(data_a),
        .macd_s_first(first_a), .macd_s_last(last_a), .macd_s_valid(valid_a),
        .macd_s_ready(macd_s_ready), .sat_flag(sat_a), .frame_err(ferr_a)
    );

    macout_stage #(.COLUMN(COLUMN), .CW(CW), .OW(OWB), .DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst), .mac_m_data(mac_m_data), .mac_m_first(mac_m_first),
        .mac_m_last(mac_m_last), .mac_m_valid(mac_m_valid), .mac_m_ready(ready_b),
        .mode(mode), .shift(shift), .sat_clr(sat_clr), .macd_s_data(data_b),
        .macd_s_first(first_b), .macd_s_last(last_b), .macd_s_valid(valid_b),
        .macd_s_ready(macd_s_ready), .sat_flag(sat_b), .frame_err(ferr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [COLUMN*OWA-1:0] da;
        logic [COLUMN*OWB-1:0] db;
        logic                  f;
        logic                  l;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_popped = 0;
    int   ferr_pulses = 0;
    bit   ferr_pending = 1'b0;
    bit   m_inframe = 1'b0;
    logic [1:0] m_mode = 2'b00;
    logic [4:0] m_shift = 5'd0;
    bit   stream_done;
    exp_t e_push;
    exp_t e_pop;

    task automatic check_val(input string tag, input logic [131:0] got, input logic [131:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint col_model(input logic [18:0] x, input logic [1:0] md,
                                         input logic [4:0] sh, input int ow);
        longint y;
        longint hi;
        longint lo;
        int     s;
        y = longint'($signed(x));
        s = (int'(sh) >= CW) ? CW - 1 : int'(sh);
        if (md[0] && s > 0) y = (y + (longint'(1) <<< (s - 1))) >>> s;
        if (md[1] && y < 0) y = 0;
        hi = (longint'(1) <<< (ow - 1)) - 1;
        lo = -(longint'(1) <<< (ow - 1));
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        return y;
    endfunction

    function automatic logic [COLUMN*CW-1:0] pack6(input int c0, input int c1, input int c2,
                                                   input int c3, input int c4, input int c5);
        logic [COLUMN*CW-1:0] d;
        int v[6];
        v = '{c0, c1, c2, c3, c4, c5};
        for (int c = 0; c < COLUMN; c++) d[c*CW +: CW] = CW'(v[c]);
        return d;
    endfunction

    function automatic logic [COLUMN*CW-1:0] rand_beat();
        logic [COLUMN*CW-1:0] d;
        for (int c = 0; c < COLUMN; c++) d[c*CW +: CW] = CW'($urandom);
        return d;
    endfunction

    // Monitor and scoreboard: pops on output handshakes, models on input accepts.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            ferr_pending = 1'b0;
            m_inframe    = 1'b0;
            m_mode       = 2'b00;
            m_shift      = 5'd0;
        end else begin
            check_val("frame_err", ferr_a, ferr_pending);
            check_val("frame_err_b", ferr_b, ferr_pending);
            check_val("ready_match", ready_b, ready_a);
            if (ferr_a) ferr_pulses++;
            ferr_pending = 1'b0;
            if (valid_a && macd_s_ready) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_beat", 1, 0);
                end else begin
                    e_pop = sb.pop_front();
                    n_popped++;
                    $display("beat %0d first=%b last=%b a=%h b=%h", n_popped, first_a, last_a, data_a, data_b);
                    check_val("data_a", data_a, e_pop.da);
                    check_val("data_b", data_b, e_pop.db);
                    check_val("first", first_a, e_pop.f);
                    check_val("last", last_a, e_pop.l);
                    check_val("valid_b", valid_b, 1);
                    check_val("first_b", first_b, e_pop.f);
                    check_val("last_b", last_b, e_pop.l);
                end
            end
            if (mac_m_valid && ready_a) begin
                logic [1:0] md;
                logic [4:0] sh;
                longint     y;
                bit         use_live;
                use_live = mac_m_first || !m_inframe;
                md = use_live ? mode : m_mode;
                sh = use_live ? shift : m_shift;
                for (int c = 0; c < COLUMN; c++) begin
                    y = col_model(mac_m_data[c*CW +: CW], md, sh, OWA);
                    e_push.da[c*OWA +: OWA] = OWA'(y);
                    y = col_model(mac_m_data[c*CW +: CW], md, sh, OWB);
                    e_push.db[c*OWB +: OWB] = OWB'(y);
                end
                e_push.f = mac_m_first;
                e_push.l = mac_m_last;
                sb.push_back(e_push);
                ferr_pending = (mac_m_first && m_inframe) ||
                               (mac_m_last && !mac_m_first && !m_inframe);
                if (mac_m_first) begin
                    m_mode  = mode;
                    m_shift = shift;
                end
                if (mac_m_last) m_inframe = 1'b0;
                else if (mac_m_first) m_inframe = 1'b1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [COLUMN*CW-1:0] d, input logic f, input logic l);
        bit acc;
        mac_m_data  = d;
        mac_m_first = f;
        mac_m_last  = l;
        mac_m_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = ready_a;
            @(posedge clk);
            #1;
        end
        mac_m_valid = 1'b0;
        if (!acc) check_val("send_timeout", 0, 1);
    endtask

    task automatic latency_check(input string tag, input logic [COLUMN*CW-1:0] d);
        mac_m_data  = d;
        mac_m_first = 1'b0;
        mac_m_last  = 1'b0;
        mac_m_valid = 1'b1;
        @(negedge clk);
        check_val({tag, "_ready"}, ready_a, 1);
        @(posedge clk);
        #1;
        mac_m_valid = 1'b0;
        @(negedge clk);
        check_val({tag, "_valid_edge1"}, valid_a, 0);
        @(negedge clk);
        check_val({tag, "_valid_edge2"}, valid_a, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check_val("drain_empty", 132'(sb.size()), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ferr_base;
        int pop_base;
        rst = 1'b1;
        mac_m_data = '0; mac_m_first = 1'b0; mac_m_last = 1'b0; mac_m_valid = 1'b0;
        mode = 2'b00; shift = 5'd0; sat_clr = 1'b0; macd_s_ready = 1'b0;
        #1;
        check_val("rst_valid", valid_a, 0);
        check_val("rst_ready", ready_a, 1);
        check_val("rst_sat", sat_a, 0);
        check_val("rst_ferr", ferr_a, 0);
        check_val("rst_first", first_a, 0);
        tick();
        rst = 1'b0;
        macd_s_ready = 1'b1;

        // Sign-extend with two-cycle latency.
        mode = 2'b00; shift = 5'd0;
        latency_check("sext", pack6(32'h40000, 5, -1, 3, 0, -100));
        drain();

        // Round-shift and saturation on the narrow instance.
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        @(negedge clk); check_val("sat_cleared", sat_b, 0); tick();
        mode = 2'b01; shift = 5'd4;
        send(pack6(1000, 24, -24, 0, 7, -7), 1'b0, 1'b0);
        @(negedge clk); check_val("sat_no_ovf", sat_b, 0); tick();
        send(pack6(5000, 1000, 24, -24, 0, 0), 1'b0, 1'b0);
        @(negedge clk); check_val("sat_set", sat_b, 1); tick();
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        @(negedge clk); check_val("sat_clr", sat_b, 0); tick();
        sat_clr = 1'b1;
        send(pack6(5000, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        sat_clr = 1'b0;
        @(negedge clk); check_val("sat_set_wins", sat_b, 1); tick();
        drain();

        // Framing: repeated first flags an error; mid-frame mode changes are ignored.
        ferr_base = ferr_pulses;
        mode = 2'b01; shift = 5'd2; send(rand_beat(), 1'b1, 1'b0);
        mode = 2'b10; shift = 5'd0; send(rand_beat(), 1'b0, 1'b0);
        mode = 2'b00;               send(rand_beat(), 1'b1, 1'b0);
        mode = 2'b11; shift = 5'd3; send(rand_beat(), 1'b0, 1'b0);
        send(rand_beat(), 1'b0, 1'b1);
        repeat (3) tick();
        check_val("frame_err_count", 132'(ferr_pulses - ferr_base), 1);
        drain();

        // Random stream with random output stalls and out-of-range shifts.
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    mode  = 2'($urandom);
                    shift = 5'($urandom);
                    send(rand_beat(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
                end
                stream_done = 1'b1;
            end
            begin
                for (int k = 0; k < 3000 && !stream_done; k++) begin
                    tick();
                    macd_s_ready = ($urandom_range(0, 2) != 0);
                end
                macd_s_ready = 1'b1;
            end
        join
        drain();

        // Backpressure: exactly DEPTH beats fit, then nothing is lost on release.
        pop_base = n_popped;
        macd_s_ready = 1'b0;
        mode = 2'b01; shift = 5'd1;
        for (int i = 0; i < DEPTH; i++) send(pack6(i, i + 100, -i, 2 * i, 0, 1), 1'b0, 1'b0);
        mac_m_data = pack6(DEPTH, 0, 0, 0, 0, 0);
        mac_m_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); check_val("bp_ready_low", ready_a, 0);
            tick();
        end
        mac_m_valid = 1'b0;
        check_val("bp_buffered", 132'(sb.size()), DEPTH);
        macd_s_ready = 1'b1;
        for (int i = DEPTH; i < 20; i++) send(pack6(i, i + 100, -i, 2 * i, 0, 1), 1'b0, 1'b0);
        drain();
        check_val("bp_popped", 132'(n_popped - pop_base), 20);

        // Reset with buffered beats clears outputs without a clock edge.
        macd_s_ready = 1'b0;
        send(rand_beat(), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(rand_beat(), 1'b0, 1'b0);
        repeat (2) tick();
        @(negedge clk);
        check_val("pre_rst_valid", valid_a, 1);
        check_val("pre_rst_first", first_a, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_valid", valid_a, 0);
        check_val("async_rst_first", first_a, 0);
        check_val("async_rst_last", last_a, 0);
        check_val("async_rst_ready", ready_a, 1);
        check_val("async_rst_sat", sat_b, 0);
        check_val("async_rst_ferr", ferr_a, 0);
        tick();
        rst = 1'b0;
        macd_s_ready = 1'b1;
        mode = 2'b11; shift = 5'd5;
        latency_check("post_rst", rand_beat());
        drain();
        check_val("sat_a_never", sat_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/macout_stage.md
MACOUT_STAGE -- requirements
Module: macout_stage

Interface
REQ-001 Parameter COLUMN, 6, number of MAC output columns.
REQ-002 Parameter CW, 19, per-column accumulator width in bits, two's complement.
REQ-003 Parameter OW, 22, per-column output width in bits; any value from 8 to 32 is legal.
REQ-004 Parameter DEPTH, 8, output FIFO entries; must be a power of two, 4 or more.
REQ-005 Port clk, in, 1: the single clock; all logic is on the rising edge.
REQ-006 Port rst, in, 1: reset, asynchronous and active-high.
REQ-007 Port mac_m_data, in, COLUMN*CW: column results; column i occupies bits [i*CW +: CW].
REQ-008 Port mac_m_first / mac_m_last / mac_m_valid, in, 1 each: frame delimiters and valid.
REQ-009 Port mac_m_ready, out, 1: stage can accept a beat.
REQ-010 Port mode, in, 2: post-process select; 00 sign-extend, 01 round-shift, 10 ReLU, 11 round-shift then ReLU.
REQ-011 Port shift, in, 5: right-shift amount for the round-shift modes.
REQ-012 Port sat_clr, in, 1: clears sat_flag.
REQ-013 Port macd_s_data, out, COLUMN*OW: processed columns, same lane order as the input.
REQ-014 Port macd_s_first / macd_s_last / macd_s_valid, out, 1 each; macd_s_ready, in, 1.
REQ-015 Port sat_flag, out, 1: sticky; set when any column saturated.
REQ-016 Port frame_err, out, 1: one-cycle pulse on a framing violation.

Function
REQ-017 Beat accept = mac_m_valid & mac_m_ready; output pop = macd_s_valid & macd_s_ready.
REQ-018 Pipeline: accept registers the processed beat into stage S1 at edge t. S1 writes the FIFO at edge t+1. With the FIFO empty, macd_s_valid is high in the cycle after edge t+1 (2-cycle latency).
REQ-019 mac_m_ready = (fifo_count + s1_valid) < DEPTH.
  - The condition is registered-free but depends only on flops.
  - No beat is ever dropped, whatever the pattern on macd_s_ready.
REQ-020 Simultaneous FIFO push and pop leaves fifo_count unchanged; a pop with the FIFO empty is impossible because macd_s_valid = !empty.
REQ-021 Sideband handling:
  - first and last travel with their beat.
  - Outputs are driven from the FIFO head; the head holds stable while valid is high and ready is low.
REQ-022 mode and shift are latched on an accepted beat with mac_m_first=1 and apply until the accepted last beat. A beat accepted outside a frame uses the live mode and shift.
REQ-023 Round-shift for shift=s > 0: y = (x + 2^(s-1)) >>> s, computed in CW+1 bits. s=0 gives y=x. Values of s ≥ CW are treated as CW-1.
REQ-024 ReLU: y<0 gives 0.
REQ-025 Width rule when OW ≥ CW: sign-extend to OW.
REQ-026 Width rule when OW < CW: saturate to [-2^(OW-1), 2^(OW-1)-1] and set sat_flag.
REQ-027 sat_flag: set wins over sat_clr in the same cycle.
REQ-028 Framing state machine, states IDLE and INFRAME:
  - An accepted first moves IDLE to INFRAME.
  - An accepted last returns to IDLE.
  - A first+last beat stays in IDLE.
REQ-029 frame_err pulses for either violation, and the beat is still forwarded:
  - an accepted first while in INFRAME (the state stays INFRAME);
  - an accepted last, without first, while in IDLE.

Reset
REQ-030 With rst high, the following are cleared immediately, regardless of clk:
  - FIFO pointers, fifo_count, s1_valid and the latched mode/shift;
  - sat_flag, frame_err and the framing state (IDLE);
  - macd_s_valid, first and last.
REQ-031 Reset asserted mid-frame discards all buffered beats; mac_m_ready is 1 in the first cycle after release.
REQ-032 macd_s_data is don't-care while macd_s_valid=0; FIFO storage is not reset.

Structure
REQ-033 Package macout_pkg holds the mode encodings (MODE_SEXT, MODE_RND, MODE_RELU, MODE_RND_RELU) and the framing state enum.
REQ-034 One sub-module, macout_fifo: a synchronous FIFO parametrised by width and DEPTH, carrying {first, last, data}, with count output. The post-process is a per-column generate loop inside macout_stage.

Verification
REQ-035 Scenario, sign-extend: CW=19, OW=22, mode=00. Column 0 = 19'h40000 → 22'h3C0000; column 1 = 5 → 5; valid at accept+2.
REQ-036 Scenario, round-shift and saturate: OW=8, mode=01, shift=4.
  - Input 1000 → 63.
  - Input 24 → 2.
  - Input -24 → -1.
  - Input 5000 → 127 with sat_flag=1. sat_clr clears it; simultaneous set+clr keeps it 1.
REQ-037 Scenario, backpressure: macd_s_ready held 0 while 20 beats are offered. Exactly DEPTH beats are accepted, then mac_m_ready=0. Releasing ready yields all beats in order, none lost or duplicated.
REQ-038 Scenario, framing: first, mid, first, last → one frame_err pulse on the second first. Mode changed mid-frame has no effect until the next first.
REQ-039 Scenario, reset: rst asserted with 5 beats buffered. Outputs go to 0 without a clk edge; after release, the next accepted beat emerges with 2-cycle latency.
